// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, stream-word field positions and clog2 helper for the FWFT FIFO
package fifo_pkg;
    localparam int FIFO_WIDTH_DATA = 73;
    localparam int FIFO_WIDTH_CTRL = 37;
    localparam int FIFO_DEPTH      = 512;
    // {tlast, tkeep[7:0], tdata[63:0]}
    localparam int DATA_TLAST_BIT  = 72;
    localparam int DATA_KEEP_LSB   = 64;
    // {tlast, tkeep[3:0], tdata[31:0]}
    localparam int CTRL_TLAST_BIT  = 36;
    localparam int CTRL_KEEP_LSB   = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: simple dual-port RAM, one write port, one registered read port
// Ports: clk, rst_n (async active-low, clears read register only),
//        i_we/i_waddr/i_wdata write port, i_raddr read address, o_rdata registered read data
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DATA,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_we,
    input  logic [clog2(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic [clog2(DEPTH)-1:0]   i_raddr,
    output logic [WIDTH-1:0]          o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read-before-write: a same-cycle write to i_raddr is seen one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_rdata <= '0;
        else        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO with programmable-full flag
// Ports: clk, rst_n (async active-low), din/wr_en write side, rd_en acknowledges dout,
//        dout head word (valid when empty=0), full, empty, prog_full,
//        data_count occupancy (only when FIFO_DATA_COUNT_EN is defined)
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH            = FIFO_WIDTH_DATA,
    parameter int DEPTH            = FIFO_DEPTH,
    parameter int PROG_FULL_THRESH = 448
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic               prog_full
`ifdef FIFO_DATA_COUNT_EN
    ,
    output logic [clog2(DEPTH):0] data_count
`endif
);
    localparam int AW = clog2(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [AW-1:0] w_raddr;

    assign full      = r_count == (AW+1)'(DEPTH);
    assign prog_full = r_count >= (AW+1)'(PROG_FULL_THRESH);
    assign empty     = r_empty;
    assign w_wr_acc  = wr_en & ~full;
    assign w_rd_acc  = rd_en & ~r_empty;
    // Prefetch the word that will be head after this edge so it lands on dout one edge later
    assign w_raddr   = r_rd_ptr + AW'(w_rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr_acc);
            r_rd_ptr <= w_raddr;
            r_count  <= r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
            // dout is valid next cycle only if the new head was written before this edge
            r_empty  <= r_count == (AW+1)'(w_rd_acc);
        end
    end

    fifo_sdp_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (w_raddr),
        .o_rdata (dout)
    );

`ifdef FIFO_DATA_COUNT_EN
    assign data_count = r_count;
`endif
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed and scoreboard tests for sync_fifo_fwft at 73 x 512
module tb_sync_fifo_fwft;
    import fifo_pkg::*;
    localparam int W  = FIFO_WIDTH_DATA;
    localparam int D  = FIFO_DEPTH;
    localparam int PT = 448;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         full;
    logic         empty;
    logic         prog_full;
`ifdef FIFO_DATA_COUNT_EN
    logic [clog2(D):0] data_count;
`endif
    int errors = 0;
    int checks = 0;

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .PROG_FULL_THRESH(PT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .prog_full (prog_full)
`ifdef FIFO_DATA_COUNT_EN
        ,
        .data_count(data_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (prog_full !== 1'b0) begin errors++; $display("FAIL reset_prog_full got %b exp 0", prog_full); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
`ifdef FIFO_DATA_COUNT_EN
        checks++; if (data_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", data_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL idle_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL idle_full got %b exp 0", full); end
        checks++; if (prog_full !== 1'b0) begin errors++; $display("FAIL idle_prog_full got %b exp 0", prog_full); end
    endtask

    task automatic test_single();
        logic [W-1:0] w;
        w = 73'h1_55_0123456789ABCDEF;
        din = w;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_latency got empty=%b exp 1", empty); end
        tick();
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", empty); end
        checks++; if (dout !== w) begin errors++; $display("FAIL single_dout got %h exp %h", dout, w); end
        checks++; if (dout[DATA_TLAST_BIT] !== 1'b1) begin errors++; $display("FAIL single_tlast got %b exp 1", dout[DATA_TLAST_BIT]); end
        checks++; if (dout[DATA_KEEP_LSB +: 8] !== 8'h55) begin errors++; $display("FAIL single_tkeep got %h exp 55", dout[DATA_KEEP_LSB +: 8]); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_drain got empty=%b exp 1", empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            din = W'(i);
            wr_en = 1'b1;
            tick();
            checks++; if (prog_full !== (i + 1 >= PT)) begin errors++; $display("FAIL fill_prog_full n=%0d got %b exp %b", i + 1, prog_full, i + 1 >= PT); end
            checks++; if (full !== (i + 1 == D)) begin errors++; $display("FAIL fill_full n=%0d got %b exp %b", i + 1, full, i + 1 == D); end
        end
`ifdef FIFO_DATA_COUNT_EN
        checks++; if (data_count !== 10'(D)) begin errors++; $display("FAIL fill_count got %0d exp %0d", data_count, D); end
`endif
        din = W'(999);
        tick();
        wr_en = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL overflow_full got %b exp 1", full); end
        checks++; if (dout !== W'(0)) begin errors++; $display("FAIL overflow_head got %h exp 0", dout); end
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_rdwr_full got %b exp 0", full); end
        checks++; if (dout !== W'(1)) begin errors++; $display("FAIL full_rdwr_head got %h exp 1", dout); end
        for (int i = 1; i < D; i++) begin
            checks++; if (empty !== 1'b0 || dout !== W'(i)) begin errors++; $display("FAIL drain_data i=%0d got %h empty=%b exp %h", i, dout, empty, W'(i)); end
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
        checks++; if (prog_full !== 1'b0) begin errors++; $display("FAIL drain_prog_full got %b exp 0", prog_full); end
    endtask

    task automatic test_back_to_back();
        int wv;
        int rv;
        wv = 0;
        rv = 0;
        for (int i = 0; i < 10; i++) begin
            din = W'(wv);
            wr_en = 1'b1;
            tick();
            wv++;
        end
        for (int i = 0; i < 1000; i++) begin
            din = W'(wv);
            wr_en = 1'b1;
            rd_en = 1'b1;
            checks++; if (empty !== 1'b0 || dout !== W'(rv)) begin errors++; $display("FAIL stream_data i=%0d got %h empty=%b exp %h", i, dout, empty, W'(rv)); end
            tick();
            wv++;
            rv++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifdef FIFO_DATA_COUNT_EN
        checks++; if (data_count !== 10'd10) begin errors++; $display("FAIL stream_count got %0d exp 10", data_count); end
`endif
        for (int i = 0; i < 10; i++) begin
            checks++; if (empty !== 1'b0 || dout !== W'(rv)) begin errors++; $display("FAIL stream_tail i=%0d got %h exp %h", i, dout, W'(rv)); end
            rd_en = 1'b1;
            tick();
            rv++;
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b exp 1", empty); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL underflow_flags got empty=%b full=%b exp 1 0", empty, full); end
        din = W'(73'h0ABC);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        checks++; if (empty !== 1'b0 || dout !== W'(73'h0ABC)) begin errors++; $display("FAIL underflow_data got %h empty=%b exp abc", dout, empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL underflow_drain got %b exp 1", empty); end
    endtask

    task automatic test_random();
        logic [W-1:0] md[$];
        int           me[$];
        int           edge_n;
        int           wp;
        logic         wa;
        logic         ra;
        logic         exp_empty;
        edge_n = 0;
        for (int i = 0; i < 10000; i++) begin
            wp = ((i / 2500) % 2 == 0) ? 75 : 25;
            exp_empty = md.size() == 0 || me[0] == edge_n;
            wr_en = $urandom_range(0, 99) < wp;
            rd_en = $urandom_range(0, 99) < (100 - wp);
            din = W'({$urandom(), $urandom(), $urandom()});
            wa = wr_en && md.size() != D;
            ra = rd_en && !exp_empty;
            tick();
            edge_n++;
            if (ra) begin
                void'(md.pop_front());
                void'(me.pop_front());
            end
            if (wa) begin
                md.push_back(din);
                me.push_back(edge_n);
            end
            exp_empty = md.size() == 0 || me[0] == edge_n;
            checks++; if (empty !== exp_empty) begin errors++; $display("FAIL rand_empty cyc=%0d got %b exp %b", i, empty, exp_empty); end
            checks++; if (full !== (md.size() == D)) begin errors++; $display("FAIL rand_full cyc=%0d got %b exp %b", i, full, md.size() == D); end
            checks++; if (prog_full !== (md.size() >= PT)) begin errors++; $display("FAIL rand_prog_full cyc=%0d got %b exp %b", i, prog_full, md.size() >= PT); end
            if (!exp_empty) begin
                checks++; if (dout !== md[0]) begin errors++; $display("FAIL rand_dout cyc=%0d got %h exp %h", i, dout, md[0]); end
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 100; i++) begin
            din = W'(5000 + i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL mid_pre_empty got %b exp 0", empty); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0 || prog_full !== 1'b0) begin errors++; $display("FAIL mid_flags got full=%b prog_full=%b exp 0 0", full, prog_full); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL mid_dout got %h exp 0", dout); end
`ifdef FIFO_DATA_COUNT_EN
        checks++; if (data_count !== '0) begin errors++; $display("FAIL mid_count got %0d exp 0", data_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        din = W'(73'h7777);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        checks++; if (empty !== 1'b0 || dout !== W'(73'h7777)) begin errors++; $display("FAIL mid_new_data got %h empty=%b exp 7777", dout, empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_new_empty got %b exp 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
